pipe_stage_skid: RTL

- Parametrised successor to the fixed-width IF/ID pipeline register.
- Generic pipeline stage register with valid/ready handshaking on both sides.
- Two-entry skid buffer, so upstream ready is registered and not combinationally dependent on downstream ready.
- Synchronous flush and global start gating; instantiated between any two pipeline stages (IF/ID, ID/EX, ...).

---
 rtl/pipe_stage_skid.sv | 118 +++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a two-entry skid buffer and valid/ready handshakes on both sides.
// Optional performance counters are compiled in when PIPE_STAGE_PERF_EN is defined.
//
// state | meaning
// EMPTY | no entries held
// ONE   | main register valid, skid register empty
// FULL  | main and skid registers both valid; upstream is back-pressured
module pipe_stage_skid #(
   parameter int                 DATA_W    = 64,
   parameter logic [DATA_W-1:0]  FLUSH_VAL = {DATA_W{1'b0}}
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              flush_i,
   input  logic              up_valid_i,
   output logic              up_ready_o,
   input  logic [DATA_W-1:0] up_data_i,
   output logic              dn_valid_o,
   input  logic              dn_ready_i,
   output logic [DATA_W-1:0] dn_data_o
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [31:0]       stall_cnt_o,
   output logic [31:0]       bubble_cnt_o
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state_q, state_nxt;
   logic [DATA_W-1:0] main_q, main_nxt;
   logic [DATA_W-1:0] skid_q, skid_nxt;
   logic              main_v, skid_v;
   logic              acc, drn;

   assign main_v = (state_q != EMPTY);
   assign skid_v = (state_q == FULL);

   // Ready depends only on held state and start, never on dn_ready_i.
   assign up_ready_o = start_i & ~skid_v;
   assign dn_valid_o = start_i & main_v;
   assign dn_data_o  = main_q;

   assign acc = up_valid_i & up_ready_o;
   assign drn = dn_valid_o & dn_ready_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= EMPTY;
         main_q  <= FLUSH_VAL;
         skid_q  <= FLUSH_VAL;
      end else begin
         state_q <= state_nxt;
         main_q  <= main_nxt;
         skid_q  <= skid_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
      if (flush_i) begin
         state_nxt = EMPTY;
         main_nxt  = FLUSH_VAL;
         skid_nxt  = FLUSH_VAL;
      end else if (start_i) begin
         case (state_q)
            EMPTY: begin
               if (acc) begin
                  state_nxt = ONE;
                  main_nxt  = up_data_i;
               end
            end
            ONE: begin
               if (acc && !drn) begin
                  state_nxt = FULL;
                  skid_nxt  = up_data_i;
               end else if (acc && drn) begin
                  main_nxt  = up_data_i;
               end else if (drn) begin
                  state_nxt = EMPTY;
               end
            end
            FULL: begin
               if (drn) begin
                  state_nxt = ONE;
                  main_nxt  = skid_q;
               end
            end
            default: begin
               state_nxt = EMPTY;
            end
         endcase
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt_o  <= 32'd0;
         bubble_cnt_o <= 32'd0;
      end else if (flush_i) begin
         stall_cnt_o  <= 32'd0;
         bubble_cnt_o <= 32'd0;
      end else if (start_i) begin
         if (dn_valid_o && !dn_ready_i) stall_cnt_o <= stall_cnt_o + 32'd1;
         if (!main_v) bubble_cnt_o <= bubble_cnt_o + 32'd1;
      end
   end
`endif

endmodule
